inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Decoupling FIFO between the fetch stage and decode/issue.
- Accepts one pipe_in_t per cycle from fetch: pc, instruction, prediction, branch, jump.
- Drives fetch's enable (stall) input from its free space.
- Presents entries in program order to the issue stage with a valid/ready handshake.
- Discards all contents on a mispredict flush from commit.

Parameters:
- DEPTH, 8: number of entries. Must be a power of 2 and at least 2.
- PTR_W, $clog2(DEPTH): read/write pointer width (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- fetch_valid  input  1  fetch presents a valid pipe_in this cycle.
- pipe_in  input  pipe_in_t (67 bits)  entry from fetch.
- enable  output  1  to fetch; 1 = queue can accept an entry this cycle.
- flush  input  1  mispredict/redirect from commit; empties the queue.
- deq_ready  input  1  issue stage accepts the head entry this cycle.
- deq_valid  output  1  head entry valid.
- pipe_out  output  pipe_in_t  head entry.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Storage: DEPTH x pipe_in_t register array, write pointer wp, read pointer rp, occupancy counter cnt.
  - wp and rp are PTR_W bits and wrap naturally modulo DEPTH.
  - cnt is PTR_W+1 bits.
- Reset (reset==0, asynchronous): wp=0, rp=0, cnt=0.
  - Outputs during and after reset: deq_valid=0, empty=1, full=0, count=0, enable=1.
  - Array contents are don't-care and are not reset.
  - Reset asserted mid-operation discards everything immediately, without waiting for a clock edge.
- Control signals:
  - enable = !full, combinational from cnt only. It does not depend on deq_ready, so there is no enqueue-through-full path.
  - enq = fetch_valid & enable & !flush.
  - deq = deq_valid & deq_ready.
  - deq_valid = !empty & !flush.
  - pipe_out = array[rp], valid only when deq_valid=1.
- Enqueue only: array[wp] <= pipe_in, wp <= wp+1, cnt <= cnt+1.
- Dequeue only: rp <= rp+1, cnt <= cnt-1.
- Simultaneous enq and deq: both pointers advance and cnt is unchanged.
  - Legal at any occupancy 1..DEPTH-1.
  - At cnt==DEPTH, enq cannot occur.
  - At cnt==0, deq cannot occur.
- Latency: an entry written at edge N is visible on pipe_out with deq_valid=1 in the cycle after edge N (1-cycle minimum), unless the optional bypass is enabled.
- Flush:
  - At the next edge: wp <= 0, rp <= 0, cnt <= 0.
  - In the flush cycle, any enq is dropped and deq_valid is forced to 0, so no dequeue occurs.
  - A flush with reset deasserted wins over any concurrent enq/deq.
  - The queue accepts new entries in the cycle after flush.
- Order: strict FIFO. Entry fields pass through unmodified; the queue does not interpret prediction, branch or jump.
- Assertions (simulation only):
  - No enq when full.
  - No deq when empty.
  - cnt never exceeds DEPTH.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- Defined:
  - When cnt==0 and fetch_valid=1 and flush=0: deq_valid=1 and pipe_out=pipe_in combinationally.
  - If deq_ready=1 in that cycle, the entry is consumed directly. No write occurs and the pointers and cnt are unchanged.
  - If deq_ready=0, the entry is enqueued normally.
  - Zero-cycle latency through an empty queue.
- Not defined: no combinational path from pipe_in to pipe_out; 1-cycle minimum latency as above.

Test Plan:
- Reset then 8 enqueues with deq_ready=0, pc=0x0,0x4,...,0x1C -> count=8, full=1, enable=0 after the 8th edge. A 9th fetch_valid is dropped. Draining returns pc 0x0..0x1C in order, then empty=1.
- Hold count=3, assert fetch_valid and deq_ready together for 5 cycles -> count stays 3; dequeued pcs are consecutive with no gap or duplicate.
- Wrap-around: 12 enqueue/dequeue pairs staggered by 2 cycles (wp passes 7->0) -> every instruction word is returned bit-exact and in order.
- Fill to 5 entries, assert flush with fetch_valid=1 and deq_ready=1 -> deq_valid=0 in the flush cycle; the next cycle gives count=0, empty=1, enable=1. The following enqueue (pc=0x100) is the next entry dequeued.
- Drive reset low asynchronously mid-cycle at count=6 -> count=0, deq_valid=0, enable=1 immediately. After release, the first enqueue appears at pipe_out one cycle later.
- With INST_QUEUE_BYPASS_EN: empty queue, fetch_valid=1, deq_ready=1, pc=0x40 -> deq_valid=1 and pipe_out.pc=0x40 in the same cycle; count stays 0.

Source files
------------

// File: rtl/inst_queue.sv
// inst_queue: in-order instruction FIFO that sits between fetch and decode/issue.
// Ports:
//   clk, reset (asynchronous, active-low)
//   fetch_valid, pipe_in  : entry offered by fetch
//   enable                : to fetch, 1 = an entry can be accepted this cycle
//   flush                 : mispredict redirect from commit; empties the queue
//   deq_ready             : issue accepts the head entry
//   deq_valid, pipe_out   : head entry presented to issue
//   count, full, empty    : occupancy status
// Optional feature macro INST_QUEUE_BYPASS_EN: lets an entry pass straight from pipe_in
// to pipe_out when the queue is empty, giving zero-cycle latency.
package inst_queue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        prediction;
        logic        branch;
        logic        jump;
    } pipe_in_t;
endpackage

module inst_queue
    import inst_queue_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           fetch_valid,
    input  pipe_in_t       pipe_in,
    output logic           enable,
    input  logic           flush,
    input  logic           deq_ready,
    output logic           deq_valid,
    output pipe_in_t       pipe_out,
    output logic [PTR_W:0] count,
    output logic           full,
    output logic           empty
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    pipe_in_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             enq, deq, pop, bypass;

    assign empty  = cnt_q == '0;
    assign full   = cnt_q == FULL_CNT;
    assign enable = !full;
    assign count  = cnt_q;

`ifdef INST_QUEUE_BYPASS_EN
    assign bypass = empty & fetch_valid & !flush;
`else
    assign bypass = 1'b0;
`endif

    assign deq_valid = (!empty & !flush) | bypass;
    assign pipe_out  = bypass ? pipe_in : mem_q[rp_q];
    assign deq       = deq_valid & deq_ready;
    // A bypassed entry consumed in the same cycle never touches storage.
    assign pop       = deq & !bypass;
    assign enq       = fetch_valid & enable & !flush & !(bypass & deq_ready);

    always_comb begin
        wp_d  = flush ? '0 : wp_q + PTR_W'(enq);
        rp_d  = flush ? '0 : rp_q + PTR_W'(pop);
        cnt_d = flush ? '0 : cnt_q + (PTR_W+1)'(enq) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem_q[wp_q] <= pipe_in;
    end

    a_no_enq_full:  assert property (@(posedge clk) disable iff (!reset) !(enq && full));
    a_no_deq_empty: assert property (@(posedge clk) disable iff (!reset) !(pop && empty));
    a_cnt_bound:    assert property (@(posedge clk) disable iff (!reset) cnt_q <= FULL_CNT);
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed self-checking bench for inst_queue.
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic       clk = 1'b0;
    logic       reset, fetch_valid, flush, deq_ready, enable, deq_valid, full, empty;
    pipe_in_t   pipe_in, pipe_out;
    logic [3:0] count;
    int         n_checks = 0;
    int         n_fail = 0;

    inst_queue #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .pipe_in(pipe_in),
        .enable(enable), .flush(flush), .deq_ready(deq_ready), .deq_valid(deq_valid),
        .pipe_out(pipe_out), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic pipe_in_t mk(input logic [31:0] pc);
        pipe_in_t p;
        p.pc          = pc;
        p.instruction = ~pc ^ 32'h1357_9BDF;
        p.prediction  = pc[2];
        p.branch      = pc[3];
        p.jump        = pc[4];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; fetch_valid = 1'b0; flush = 1'b0; deq_ready = 1'b0; pipe_in = '0;
        #12;
        chk("rst_count", 67'(count), 67'd0);
        chk("rst_empty", 67'(empty), 67'd1);
        chk("rst_full", 67'(full), 67'd0);
        chk("rst_enable", 67'(enable), 67'd1);
        chk("rst_deq_valid", 67'(deq_valid), 67'd0);
        @(posedge clk); #1 reset = 1'b1;

        // Fill to DEPTH with issue stalled, then offer a 9th entry that must be dropped.
        fetch_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pipe_in = mk(32'(i * 4));
            step();
        end
        chk("fill_count", 67'(count), 67'd8);
        chk("fill_full", 67'(full), 67'd1);
        chk("fill_enable", 67'(enable), 67'd0);
        pipe_in = mk(32'h20);
        step();
        chk("ninth_dropped", 67'(count), 67'd8);
        fetch_valid = 1'b0;
        deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", 67'(deq_valid), 67'd1);
            chk("drain_entry", 67'(pipe_out), 67'(mk(32'(i * 4))));
            step();
        end
        chk("drain_empty", 67'(empty), 67'd1);
        chk("drain_no_valid", 67'(deq_valid), 67'd0);
        deq_ready = 1'b0;

        // Steady state at count 3 with simultaneous enqueue and dequeue.
        fetch_valid = 1'b1;
        pipe_in = mk(32'h200);
        #1;
`ifdef INST_QUEUE_BYPASS_EN
        chk("empty_bypass_valid", 67'(deq_valid), 67'd1);
`else
        chk("empty_no_bypass", 67'(deq_valid), 67'd0);
`endif
        step();
        for (int i = 1; i < 3; i++) begin
            pipe_in = mk(32'h200 + 32'(i * 4));
            step();
        end
        chk("pair_start_count", 67'(count), 67'd3);
        deq_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pipe_in = mk(32'h20C + 32'(i * 4));
            #1;
            chk("pair_entry", 67'(pipe_out), 67'(mk(32'h200 + 32'(i * 4))));
            step();
            chk("pair_count", 67'(count), 67'd3);
        end
        fetch_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("pair_tail", 67'(pipe_out), 67'(mk(32'h214 + 32'(i * 4))));
            step();
        end
        chk("pair_empty", 67'(empty), 67'd1);
        deq_ready = 1'b0;

        // Wrap-around: dequeues trail enqueues by two cycles over 12 entries.
        for (int c = 0; c < 14; c++) begin
            fetch_valid = c < 12;
            deq_ready = c >= 2;
            pipe_in = mk(32'h1000 + 32'(c * 4));
            pipe_in.instruction = 32'hA500_0000 ^ (32'(c) * 32'h0101_0101);
            #1;
            if (c >= 2) begin
                chk("wrap_valid", 67'(deq_valid), 67'd1);
                chk("wrap_instr", 67'(pipe_out.instruction), 67'(32'hA500_0000 ^ (32'(c - 2) * 32'h0101_0101)));
            end
            step();
        end
        chk("wrap_empty", 67'(empty), 67'd1);
        fetch_valid = 1'b0; deq_ready = 1'b0;

        // Flush at count 5 beats a concurrent enqueue and dequeue.
        fetch_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pipe_in = mk(32'h300 + 32'(i * 4));
            step();
        end
        chk("pre_flush_count", 67'(count), 67'd5);
        flush = 1'b1; deq_ready = 1'b1; pipe_in = mk(32'h999);
        #1;
        chk("flush_deq_valid", 67'(deq_valid), 67'd0);
        step();
        flush = 1'b0; fetch_valid = 1'b0; deq_ready = 1'b0;
        chk("flush_count", 67'(count), 67'd0);
        chk("flush_empty", 67'(empty), 67'd1);
        chk("flush_enable", 67'(enable), 67'd1);
        fetch_valid = 1'b1; pipe_in = mk(32'h100);
        step();
        fetch_valid = 1'b0; deq_ready = 1'b1;
        chk("post_flush_valid", 67'(deq_valid), 67'd1);
        chk("post_flush_entry", 67'(pipe_out), 67'(mk(32'h100)));
        step();
        chk("post_flush_empty", 67'(empty), 67'd1);
        deq_ready = 1'b0;

        // Asynchronous reset in the middle of a cycle at count 6.
        fetch_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pipe_in = mk(32'h400 + 32'(i * 4));
            step();
        end
        fetch_valid = 1'b0;
        chk("pre_reset_count", 67'(count), 67'd6);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_count", 67'(count), 67'd0);
        chk("async_rst_valid", 67'(deq_valid), 67'd0);
        chk("async_rst_enable", 67'(enable), 67'd1);
        step();
        reset = 1'b1;
        fetch_valid = 1'b1; pipe_in = mk(32'h500);
        step();
        fetch_valid = 1'b0;
        chk("post_rst_valid", 67'(deq_valid), 67'd1);
        chk("post_rst_entry", 67'(pipe_out), 67'(mk(32'h500)));
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        chk("post_rst_empty", 67'(empty), 67'd1);

`ifdef INST_QUEUE_BYPASS_EN
        fetch_valid = 1'b1; deq_ready = 1'b1; pipe_in = mk(32'h40);
        #1;
        chk("bypass_valid", 67'(deq_valid), 67'd1);
        chk("bypass_pc", 67'(pipe_out.pc), 67'h40);
        step();
        fetch_valid = 1'b0; deq_ready = 1'b0;
        chk("bypass_count", 67'(count), 67'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
